// File: rtl/tri_bus_arbiter.sv
// rtl/tri_bus_arbiter.sv - round-robin tri-state bus arbiter with dead-cycle turnaround
// Optional forced release after MAX_HOLD owner cycles: define ARB_TIMEOUT_EN.
module tri_bus_arbiter #(
    parameter int NREQ     = 4,
    parameter int TURN_CYC = 1,
    parameter int MAX_HOLD = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         drv_en,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    busy,
    output logic                    timeout
);

    localparam int OW = $clog2(NREQ);
    localparam int CW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
    localparam logic [CW-1:0] TURN_LAST = CW'(TURN_CYC - 1);

    if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
        $error("tri_bus_arbiter: NREQ out of range 2..16");
    end
    if (TURN_CYC < 1) begin : g_bad_turn
        $error("tri_bus_arbiter: TURN_CYC must be at least 1");
    end
    if (MAX_HOLD < 2) begin : g_bad_hold
        $error("tri_bus_arbiter: MAX_HOLD must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [NREQ-1:0] r_gnt, w_gnt_nxt;
    logic [NREQ-1:0] r_drv_en;
    logic [OW-1:0]   r_owner, w_owner_nxt;
    logic [OW-1:0]   r_ptr, w_ptr_nxt;
    logic [CW-1:0]   r_turn_cnt, w_turn_nxt;

    logic            w_any;
    logic [OW-1:0]   w_win;
    logic [NREQ-1:0] w_win_oh;
    logic            w_grant;
    logic            w_release;
    int              w_best;

`ifdef ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0] r_hold, w_hold_nxt, w_hold_inc;
    logic          r_timeout, w_timeout_nxt;
    logic          w_others;

    // w_hold_inc counts the current GRANT cycle too, so release lands after exactly MAX_HOLD cycles
    assign w_hold_inc = (r_hold == HW'(MAX_HOLD)) ? r_hold : r_hold + 1'b1;
    assign w_others   = |(req & ~r_gnt);
`endif

    // Distance of idx from the search start (base+1); the former owner is furthest away.
    function automatic int rr_dist(input int idx, input int base);
        return (idx - base - 1 + NREQ) % NREQ;
    endfunction

    always_comb begin : arb_search
        w_best = NREQ;
        w_any  = 1'b0;
        w_win  = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (req[j] && (rr_dist(j, int'(r_ptr)) < w_best)) begin
                w_best = rr_dist(j, int'(r_ptr));
                w_any  = 1'b1;
                w_win  = OW'(j);
            end
        end
    end

    assign w_win_oh = NREQ'(1) << w_win;

    always_comb begin : fsm_next
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_turn_nxt  = r_turn_cnt;
        w_grant     = 1'b0;
        w_release   = 1'b0;
`ifdef ARB_TIMEOUT_EN
        w_hold_nxt    = r_hold;
        w_timeout_nxt = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                w_grant = w_any;
            end
            GRANT: begin
                if (!req[r_owner]) begin
                    w_release = 1'b1;
`ifdef ARB_TIMEOUT_EN
                end else if ((w_hold_inc == HW'(MAX_HOLD)) && w_others) begin
                    w_release     = 1'b1;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_hold_nxt = w_hold_inc;
`endif
                end
            end
            TURN: begin
                if (r_turn_cnt == TURN_LAST) begin
                    w_turn_nxt = '0;
                    if (w_any) begin
                        w_grant = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_turn_nxt = r_turn_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
        endcase

        if (w_release) begin
            w_state_nxt = TURN;
            w_gnt_nxt   = '0;
            w_turn_nxt  = '0;
        end

        if (w_grant) begin
            w_state_nxt = GRANT;
            w_gnt_nxt   = w_win_oh;
            w_owner_nxt = w_win;
            w_ptr_nxt   = w_win;
            w_turn_nxt  = '0;
`ifdef ARB_TIMEOUT_EN
            w_hold_nxt  = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin : fsm_regs
        if (rst) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_drv_en   <= '0;
            r_owner    <= '0;
            r_ptr      <= OW'(NREQ - 1);
            r_turn_cnt <= '0;
`ifdef ARB_TIMEOUT_EN
            r_hold     <= '0;
            r_timeout  <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_drv_en   <= w_gnt_nxt;
            r_owner    <= w_owner_nxt;
            r_ptr      <= w_ptr_nxt;
            r_turn_cnt <= w_turn_nxt;
`ifdef ARB_TIMEOUT_EN
            r_hold     <= w_hold_nxt;
            r_timeout  <= w_timeout_nxt;
`endif
        end
    end

    assign gnt    = r_gnt;
    assign drv_en = r_drv_en;
    assign owner  = r_owner;
    assign busy   = |r_gnt;
`ifdef ARB_TIMEOUT_EN
    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

endmodule
